vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port 320x240x12 frame-buffer block RAM between two requesters: the VGA pixel fetch path (read, strict priority) and a drawing/update engine (write, posted through an internal FIFO).
- Sits between the address generator / VGA controller on one side and the block RAM on the other.
- Guarantees a fixed display read latency and drains buffered writes only in cycles the display does not use.

Parameters:
- ADDR_W, 17, frame-buffer address width
- DATA_W, 12, pixel width (4:4:4 RGB)
- FIFO_DEPTH, 8, write FIFO entries; power of two, minimum 2
- MAX_WAIT, 1023, consecutive blocked cycles with a pending write before `starve` asserts

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- disp_req  in  1  display needs one pixel this cycle
- disp_addr  in  ADDR_W  pixel address, sampled when disp_req=1
- disp_data  out  DATA_W  fetched pixel
- disp_valid  out  1  disp_data valid this cycle
- wr_req  in  1  writer offers one write
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- wr_ready  out  1  FIFO can accept; a write is accepted when wr_req & wr_ready
- mem_addr  out  ADDR_W  block RAM address (registered)
- mem_we  out  1  block RAM write enable (registered)
- mem_din  out  DATA_W  block RAM write data (registered)
- mem_dout  in  DATA_W  block RAM read data, 1-cycle latency
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- starve_clr  in  1  clears sticky starve flag
- starve  out  1  sticky starvation flag
- stall_cnt  out  16  blocked-write cycle counter (optional feature)

Behaviour:
- Reset (async, rst=1): outputs take these values:
  - mem_addr=0, mem_we=0, mem_din=0
  - disp_data=0, disp_valid=0
  - FIFO empty, fifo_level=0, wr_ready=1
  - starve=0, stall_cnt=0, wait counter=0
  - Read pipeline valid bits cleared; in-flight reads are discarded and never reported.
- Command select, evaluated each cycle t and registered at the edge ending t:
  - CMD_RD if disp_req=1: mem_addr<=disp_addr, mem_we<=0.
  - Else CMD_WR if FIFO non-empty: pop head; mem_addr<=head.addr, mem_din<=head.data, mem_we<=1.
  - Else CMD_IDLE: mem_we<=0, mem_addr holds.
- Display read latency is exactly 3 cycles:
  - disp_req at cycle t → command in t+1 → mem_dout in t+2 → disp_data/disp_valid registered in t+3.
  - disp_valid is a 1-cycle pulse per request. Back-to-back requests give back-to-back valid pulses.
  - disp_data holds its value when disp_valid=0.
- Write FIFO:
  - wr_ready = (fifo_level != FIFO_DEPTH), combinational from occupancy.
  - Push and pop in the same cycle: level unchanged.
  - When full, no push occurs even if a pop happens that cycle; wr_ready rises the following cycle.
  - Writes reach memory in strict FIFO order.
- Hazard: a display read of an address with a write still pending returns the old memory contents. No forwarding.
- Starvation:
  - Wait counter increments each cycle the FIFO is non-empty and disp_req=1.
  - It resets to 0 on any pop or when the FIFO is empty.
  - When the counter reaches MAX_WAIT, starve<=1 (sticky); the counter saturates.
  - starve_clr clears starve the next cycle. If starve_clr and the set condition coincide, set wins.
- Display is never stalled or dropped. The writer is back-pressured only via wr_ready.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined: stall_cnt increments (saturating at 16'hFFFF) each cycle the FIFO is non-empty and disp_req=1. It is cleared by rst or starve_clr.
- Undefined: stall_cnt is constant 0 and no counter logic is built.

Decomposition:
- Package vram_arb_pkg:
  - ADDR_W/DATA_W defaults
  - command enum CMD_IDLE/CMD_RD/CMD_WR
  - write-entry struct {addr, data}
- Sub-module vram_wr_fifo: synchronous FIFO with FIFO_DEPTH entries, push/pop/level/full/empty, same clk/rst.
- Arbitration, read pipeline, starvation and stats logic live in vram_arbiter.

Test Plan:
- Reset mid-read: disp_req at t, rst pulsed at t+1 → no disp_valid at t+3; all outputs at reset values; wr_ready=1.
- Latency: preload addr 0x00010=12'hABC; disp_req with disp_addr=0x00010 at t → disp_valid=1, disp_data=12'hABC at exactly t+3.
- Blanking drain: disp_req=0; push 3 writes (0x5→12'h111, 0x6→12'h222, 0x7→12'h333) → mem_we pulses in that order on consecutive cycles; fifo_level returns to 0.
- Backpressure: disp_req held 1; push 8 writes → wr_ready=0, fifo_level=8, mem_we never 1; drop disp_req → first write issued next cycle and wr_ready=1 one cycle after the pop.
- Starvation: MAX_WAIT=15; 1 write pending, disp_req held 1 → starve=1 after 15 blocked cycles; starve_clr → starve=0 next cycle; with VRAM_ARB_STATS_EN, stall_cnt matches the blocked-cycle count.
- Hazard: pending write 0x20→12'hFFF blocked by active display; read 0x20 during the block → old value returned; after the drain, a read returns 12'hFFF.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the frame-buffer arbiter.
package vram_arb_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_RD   = 2'd1,
    CMD_WR   = 2'd2
  } cmd_e;

  // Posted-write entry at the default frame-buffer geometry.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write FIFO; a push is refused while full even if a pop happens.
module vram_wr_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];
  assign level_o = level_q;

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Frame-buffer arbiter: display reads have strict priority, writes drain from a FIFO.
// Optional blocked-cycle statistics counter enabled by VRAM_ARB_STATS_EN.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_WAIT   = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          disp_req,
  input  logic [ADDR_W-1:0]             disp_addr,
  output logic [DATA_W-1:0]             disp_data,
  output logic                          disp_valid,
  input  logic                          wr_req,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_ready,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_din,
  input  logic [DATA_W-1:0]             mem_dout,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          starve_clr,
  output logic                          starve,
  output logic [15:0]                   stall_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            push_entry, head;
  logic              fifo_full, fifo_empty, pop, blocked;
  cmd_e              cmd;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              rd1_q, rd2_q, disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              starve_q, starve_d;

  assign push_entry = '{addr: wr_addr, data: wr_data};

  vram_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_req),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wr_ready = !fifo_full;
  assign blocked  = disp_req && !fifo_empty;
  assign pop      = (cmd == CMD_WR);

  always_comb begin
    cmd = CMD_IDLE;
    if (disp_req)         cmd = CMD_RD;
    else if (!fifo_empty) cmd = CMD_WR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
    end else begin
      case (cmd)
        CMD_RD: begin
          mem_addr_q <= disp_addr;
          mem_we_q   <= 1'b0;
        end
        CMD_WR: begin
          mem_addr_q <= head.addr;
          mem_din_q  <= head.data;
          mem_we_q   <= 1'b1;
        end
        default: mem_we_q <= 1'b0;
      endcase
    end
  end

  // rd1: command on the RAM port; rd2: mem_dout carries the pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q        <= 1'b0;
      rd2_q        <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      rd1_q        <= disp_req;
      rd2_q        <= rd1_q;
      disp_valid_q <= rd2_q;
      if (rd2_q) disp_data_q <= mem_dout;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (fifo_empty || pop)
      wait_d = '0;
    else if (blocked && wait_q != WAIT_W'(MAX_WAIT))
      wait_d = wait_q + 1'b1;
  end

  // Set fires on the step that brings the counter to MAX_WAIT and beats a clear.
  always_comb begin
    starve_d = starve_q;
    if (blocked && wait_q == WAIT_W'(MAX_WAIT - 1)) starve_d = 1'b1;
    else if (starve_clr)                            starve_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              stall_q <= '0;
    else if (starve_clr)                  stall_q <= '0;
    else if (blocked && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_din    = mem_din_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign starve     = starve_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle-latency block RAM model.
module tb_vram_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
`ifdef VRAM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk, rst;
  logic              disp_req, disp_valid, wr_req, wr_ready, mem_we, starve_clr, starve;
  logic [ADDR_W-1:0] disp_addr, wr_addr, mem_addr;
  logic [DATA_W-1:0] disp_data, wr_data, mem_din, mem_dout;
  logic [3:0]        fifo_level;
  logic [15:0]       stall_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(8), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .fifo_level(fifo_level), .starve_clr(starve_clr), .starve(starve), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; disp_req = 1'b0; disp_addr = '0; wr_req = 1'b0;
    wr_addr = '0; wr_data = '0; starve_clr = 1'b0;
    step(); step();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_level", fifo_level, 0);
    rst = 1'b0;

    // Reset arriving while a read is in flight must swallow it.
    disp_req = 1'b1; disp_addr = 17'h00010;
    step();
    chk("pre_rst_addr", mem_addr, 17'h00010);
    disp_req = 1'b0; rst = 1'b1;
    #1;
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_data", disp_data, 0);
    chk("async_rst_starve", starve, 0);
    chk("async_rst_stall", stall_cnt, 0);
    step();
    rst = 1'b0;
    step();
    chk("rst_mid_read_valid", disp_valid, 0);
    chk("rst_mid_read_ready", wr_ready, 1);
    step();
    chk("rst_mid_read_valid2", disp_valid, 0);

    // Preload 0x10=ABC and 0x20=555 through the write path.
    wr_req = 1'b1; wr_addr = 17'h00010; wr_data = 12'hABC;
    step();
    wr_addr = 17'h00020; wr_data = 12'h555;
    step();
    chk("pre_we0", mem_we, 1);
    chk("pre_addr0", mem_addr, 17'h00010);
    chk("pre_din0", mem_din, 12'hABC);
    wr_req = 1'b0;
    step();
    chk("pre_addr1", mem_addr, 17'h00020);
    chk("pre_din1", mem_din, 12'h555);
    step();
    chk("pre_we_off", mem_we, 0);
    chk("pre_level", fifo_level, 0);

    // Exact 3-cycle latency, then back-to-back reads.
    disp_req = 1'b1; disp_addr = 17'h00010;
    step();
    disp_req = 1'b0;
    chk("lat_cmd_addr", mem_addr, 17'h00010);
    chk("lat_v1", disp_valid, 0);
    step();
    chk("lat_v2", disp_valid, 0);
    step();
    chk("lat_v3", disp_valid, 1);
    chk("lat_d3", disp_data, 12'hABC);
    step();
    chk("lat_v4", disp_valid, 0);
    chk("lat_hold", disp_data, 12'hABC);
    disp_req = 1'b1; disp_addr = 17'h00020;
    step();
    disp_addr = 17'h00010;
    step();
    disp_req = 1'b0;
    step();
    chk("b2b_v0", disp_valid, 1);
    chk("b2b_d0", disp_data, 12'h555);
    step();
    chk("b2b_v1", disp_valid, 1);
    chk("b2b_d1", disp_data, 12'hABC);
    step();
    chk("b2b_v2", disp_valid, 0);

    // Blanking drain of three writes.
    wr_req = 1'b1; wr_addr = 17'h5; wr_data = 12'h111;
    step();
    chk("drain_lvl0", fifo_level, 1);
    wr_addr = 17'h6; wr_data = 12'h222;
    step();
    chk("drain_we0", mem_we, 1);
    chk("drain_a0", mem_addr, 17'h5);
    chk("drain_d0", mem_din, 12'h111);
    wr_addr = 17'h7; wr_data = 12'h333;
    step();
    wr_req = 1'b0;
    chk("drain_a1", mem_addr, 17'h6);
    chk("drain_d1", mem_din, 12'h222);
    step();
    chk("drain_a2", mem_addr, 17'h7);
    chk("drain_d2", mem_din, 12'h333);
    chk("drain_lvl", fifo_level, 0);
    step();
    chk("drain_we_off", mem_we, 0);

    // Backpressure with the display holding the port.
    disp_req = 1'b1; disp_addr = 17'h0;
    for (int i = 0; i < 8; i++) begin
      wr_req = 1'b1; wr_addr = 17'h40 + 17'(i); wr_data = 12'h100 + 12'(i);
      step();
      chk("bp_no_we", mem_we, 0);
    end
    chk("bp_full_lvl", fifo_level, 8);
    chk("bp_ready_low", wr_ready, 0);
    wr_addr = 17'h99; wr_data = 12'h999;
    step();
    chk("bp_full_hold", fifo_level, 8);
    chk("bp_stall", stall_cnt, STATS ? 8 : 0);
    disp_req = 1'b0;
    step();
    wr_req = 1'b0;
    chk("bp_first_we", mem_we, 1);
    chk("bp_first_addr", mem_addr, 17'h40);
    chk("bp_first_din", mem_din, 12'h100);
    chk("bp_no_push_full", fifo_level, 7);
    chk("bp_ready_up", wr_ready, 1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("bp_order", mem_addr, 17'h40 + 17'(i));
    end
    step();
    chk("bp_empty", fifo_level, 0);
    chk("bp_no_starve", starve, 0);

    // Starvation and read-after-pending-write hazard on 0x20.
    disp_req = 1'b1; disp_addr = 17'h20;
    wr_req = 1'b1; wr_addr = 17'h20; wr_data = 12'hFFF;
    step();
    wr_req = 1'b0;
    for (int k = 2; k <= 18; k++) begin
      step();
      if (k == 3) begin
        chk("hz_valid", disp_valid, 1);
        chk("hz_old_data", disp_data, 12'h555);
      end
      if (k == 15) chk("st_not_yet", starve, 0);
      if (k == 16) begin
        chk("st_set", starve, 1);
        chk("st_stall", stall_cnt, STATS ? 15 : 0);
        chk("st_blocked_we", mem_we, 0);
      end
      if (k == 18) chk("st_sticky", starve, 1);
    end
    chk("st_stall_sat", stall_cnt, STATS ? 17 : 0);
    disp_req = 1'b0; starve_clr = 1'b1;
    step();
    starve_clr = 1'b0;
    chk("st_clr", starve, 0);
    chk("st_clr_stall", stall_cnt, 0);
    chk("hz_drain_we", mem_we, 1);
    chk("hz_drain_din", mem_din, 12'hFFF);
    step();
    disp_req = 1'b1; disp_addr = 17'h20;
    step();
    disp_req = 1'b0;
    step(); step();
    chk("hz_new_valid", disp_valid, 1);
    chk("hz_new_data", disp_data, 12'hFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
